// File: rtl/sample_capture_drain.sv
// Capture buffer: records upstream samples by address while load is high.
// When load drops, it drains indices 0..hi_idx in order over a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for the first load after reset
// CAPTURE | load window open, writing samples on address change
// DRAIN   | streaming buffer[0..hi_idx] to the consumer
// DONE    | drain finished, waiting for the next load window
module sample_capture_drain #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   address,
  input  logic [15:0]   out,
  input  logic          load,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [15:0]   m_data,
  output logic [AW-1:0] m_index,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam logic [31:0] DEPTH = 32'd1 << AW;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   buffer [DEPTH];
  logic [15:0]   last_addr;
  logic [AW-1:0] hi_idx;
  logic [AW-1:0] rd_ptr;
  logic          written;
  logic          issued_all;

  logic          entering, in_cap, wr_req, in_range, wr_ok, fetch;
  logic [AW-1:0] addr_lo;

  // The cycle that opens the window counts as the first capture cycle,
  // so its sample is written unconditionally.
  always_comb begin
    entering = load && (state == IDLE || state == DONE);
    in_cap   = load && (state == CAPTURE);
    wr_req   = entering || (in_cap && (address != last_addr));
    in_range = ({16'd0, address} < DEPTH);
    wr_ok    = wr_req && in_range;
    addr_lo  = address[AW-1:0];
    fetch    = (state == DRAIN) && written && !issued_all && (!m_valid || m_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CAPTURE;
      CAPTURE: if (!load) state_nxt = DRAIN;
      DRAIN: begin
        if (!written)                         state_nxt = DONE;
        else if (m_valid && m_ready && m_last) state_nxt = DONE;
      end
      DONE:    if (load) state_nxt = CAPTURE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CAPTURE) || (state == DRAIN);
    done = (state == DONE);
  end

  // Buffer has no reset so stale entries drain as-is.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) buffer[addr_lo] <= out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr  <= '0;
      hi_idx     <= '0;
      written    <= 1'b0;
      overflow   <= 1'b0;
    end else if (entering) begin
      last_addr  <= address;
      hi_idx     <= wr_ok ? addr_lo : '0;
      written    <= wr_ok;
      overflow   <= !in_range;
    end else if (in_cap) begin
      last_addr  <= address;
      if (wr_ok) begin
        written  <= 1'b1;
        if (addr_lo > hi_idx) hi_idx <= addr_lo;
      end
      if (wr_req && !in_range) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      issued_all <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_index    <= '0;
      m_last     <= 1'b0;
    end else if (entering) begin
      rd_ptr     <= '0;
      issued_all <= 1'b0;
      m_valid    <= 1'b0;
    end else if (fetch) begin
      m_valid    <= 1'b1;
      m_data     <= buffer[rd_ptr];
      m_index    <= rd_ptr;
      m_last     <= (rd_ptr == hi_idx);
      if (rd_ptr == hi_idx) issued_all <= 1'b1;
      else                  rd_ptr     <= rd_ptr + 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_capture_drain.sv
// Directed and randomized capture/drain scenarios checked against an
// address-indexed array model of the buffer.
module tb_sample_capture_drain;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset, load, m_ready;
  logic [15:0]   address, out;
  logic          m_valid, m_last, busy, done, overflow;
  logic [15:0]   m_data;
  logic [AW-1:0] m_index;

  int n_assert = 0;
  int n_fail = 0;

  logic [15:0] model_mem [DEPTH];
  int          m_hi;
  bit          m_wr, m_ovf;
  logic [15:0] cap_a [$];
  logic [15:0] cap_d [$];

  sample_capture_drain #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .address(address), .out(out), .load(load),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d);
    cap_a.push_back(a);
    cap_d.push_back(d);
  endtask

  // Model: a sample is stored when its address differs from the previous
  // cycle's address (or it opens the window); out-of-range addresses only flag.
  task automatic capture();
    logic [15:0] last;
    bit first;
    first = 1;
    last = '0;
    m_hi = 0; m_wr = 0; m_ovf = 0;
    for (int i = 0; i < cap_a.size(); i++) begin
      load = 1; address = cap_a[i]; out = cap_d[i];
      if (first || cap_a[i] != last) begin
        if (int'(cap_a[i]) < DEPTH) begin
          model_mem[int'(cap_a[i])] = cap_d[i];
          m_wr = 1;
          if (int'(cap_a[i]) > m_hi) m_hi = int'(cap_a[i]);
        end else m_ovf = 1;
      end
      first = 0;
      last = cap_a[i];
      step();
      if (i == 0) chk("busy_in_capture", busy, 1);
    end
    chk("overflow_after_capture", overflow, m_ovf);
    load = 0;
    step();
    cap_a.delete();
    cap_d.delete();
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; else random ready
  task automatic drain(input int mode, input int pulse_cyc);
    int exp_i, cyc, first_v;
    bit stall, rdy, saw_v;
    logic [15:0] pd;
    logic [AW-1:0] pi;
    logic pl;
    exp_i = 0; cyc = 0; first_v = -1; stall = 0; saw_v = 0;
    pd = '0; pi = '0; pl = 0;
    chk("busy_in_drain", busy, 1);
    while (!done && cyc < 3000) begin
      if (stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_index", m_index, pi);
        chk("hold_last", m_last, pl);
      end
      case (mode)
        0:       rdy = 1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready = rdy;
      load = (cyc == pulse_cyc);
      address = 16'($urandom);
      out = 16'($urandom);
      if (m_valid) begin
        if (!saw_v) first_v = cyc;
        saw_v = 1;
        if (rdy) begin
          chk("drain_index", m_index, exp_i);
          chk("drain_data", m_data, model_mem[exp_i]);
          chk("drain_last", m_last, exp_i == m_hi);
          exp_i++;
        end
        stall = !rdy; pd = m_data; pi = m_index; pl = m_last;
      end else stall = 0;
      step();
      cyc++;
    end
    load = 0;
    m_ready = 0;
    chk("drain_timeout", cyc < 3000, 1);
    chk("drain_count", exp_i, m_wr ? m_hi + 1 : 0);
    chk("done_flag", done, 1);
    chk("busy_in_done", busy, 0);
    chk("overflow_held", overflow, m_ovf);
    if (m_wr) begin
      chk("first_valid_latency", (first_v >= 0) && (first_v <= 2), 1);
      if (mode == 0) chk("throughput", cyc - first_v, m_hi + 1);
    end else chk("no_valid_when_empty", saw_v, 0);
  endtask

  initial begin
    int cyc;
    logic [15:0] a;
    reset = 1; load = 0; m_ready = 0; address = '0; out = '0;
    step(); step();
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", m_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    reset = 0;
    step();
    chk("idle_busy", busy, 0);

    // fill every entry so later drains never see unknown contents
    for (int i = 0; i < DEPTH; i++) push(16'(i), 16'($urandom));
    capture();
    drain(2, -1);

    push(16'd0, 16'hFFFF); push(16'd1, 16'h0); push(16'd2, 16'h0); push(16'd3, 16'h0);
    capture();
    drain(0, -1);

    push(16'd0, 16'h1111); push(16'd0, 16'h2222); push(16'd5, 16'h3333);
    capture();
    drain(0, -1);

    push(16'd2, 16'hABCD); push(16'd300, 16'h5555);
    capture();
    drain(1, -1);

    push(16'd300, 16'h1234); push(16'd999, 16'h4321);
    capture();
    drain(0, -1);

    // load pulse mid-drain must be ignored; the new window clears overflow
    for (int i = 0; i < 8; i++) push(16'(i), 16'($urandom));
    capture();
    drain(2, 2);

    for (int i = 0; i < 6; i++) push(16'(i), 16'($urandom));
    capture();
    m_ready = 1;
    cyc = 0;
    while (!(m_valid && m_index == 2) && cyc < 50) begin step(); cyc++; end
    chk("reach_index2", cyc < 50, 1);
    reset = 1;
    step();
    reset = 0;
    m_ready = 0;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_index", m_index, 0);
    chk("midrst_data", m_data, 0);
    chk("midrst_last", m_last, 0);
    step();
    chk("idle_after_rst", busy, 0);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 12);
      a = '0;
      for (int i = 0; i < n; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 70)      a = 16'($urandom_range(0, 15));
        else if (r < 85) a = a;
        else             a = 16'($urandom_range(256, 65535));
        push(a, 16'($urandom));
      end
      capture();
      drain(t % 3, (t == 4) ? 1 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
